// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    localparam int         DEF_DATA_W = 17;
    localparam int         DEF_ADDR_W = 8;
    localparam logic [7:0] DEF_SYNC   = 8'hA5;
    localparam int         WORD_BYTES = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_WRITE,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// Host-side program loader: parses a framed byte stream, writes words into
// core memory, checks the XOR checksum and then releases the core to run.
//
// state  | meaning
// IDLE   | after reset, waiting for SYNC, junk bytes dropped
// HDR_HI | expecting word count high byte
// HDR_LO | expecting word count low byte
// B0     | expecting word byte 0 (bits 23:16)
// B1     | expecting word byte 1 (bits 15:8)
// B2     | expecting word byte 2 (bits 7:0)
// WRITE  | memory write cycle, no byte accepted
// CSUM   | expecting checksum byte
// RUN    | core released and running, only SYNC restarts
// ERROR  | bad frame, core held in reset, only SYNC restarts
module prog_loader
    import loader_pkg::*;
#(
    parameter int         DATA_W = DEF_DATA_W,
    parameter int         ADDR_W = DEF_ADDR_W,
    parameter logic [7:0] SYNC   = DEF_SYNC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_reset,
    output logic              core_run,
    output logic              loading,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    // Padding bits above the word live entirely in byte 0.
    localparam int PAD_BITS = WORD_BYTES * 8 - DATA_W;

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [7:0]        n_hi_q, n_hi_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              bad_q, bad_d;
    logic              b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              core_reset_q, core_reset_d;
    logic              core_run_q, core_run_d;
    logic              loading_q, loading_d;
    logic              load_err_q, load_err_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

    logic              accept;
    logic [15:0]       n_full;
    logic [ADDR_W:0]   idx_inc;

    assign rx_ready = (state_q != ST_WRITE);
    assign accept   = rx_valid & rx_ready;
    assign n_full   = {n_hi_q, rx_data};
    assign idx_inc  = idx_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        n_hi_d         = n_hi_q;
        idx_d          = idx_q;
        csum_d         = csum_q;
        bad_d          = bad_q;
        b0_d           = b0_q;
        b1_d           = b1_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        core_reset_d   = core_reset_q;
        core_run_d     = core_run_q;
        loading_d      = loading_q;
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (accept && rx_data == SYNC) begin
                    csum_d         = 8'h00;
                    idx_d          = '0;
                    bad_d          = 1'b0;
                    load_err_d     = 1'b0;
                    words_loaded_d = '0;
                    loading_d      = 1'b1;
                    core_reset_d   = 1'b1;
                    core_run_d     = 1'b0;
                    state_d        = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    n_hi_d  = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept) begin
                    n_d    = n_full;
                    csum_d = csum_q ^ rx_data;
                    if (32'(n_full) > (32'd1 << ADDR_W)) begin
                        load_err_d = 1'b1;
                        loading_d  = 1'b0;
                        state_d    = ST_ERROR;
                    end else if (n_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_B0;
                    end
                end
            end
            ST_B0: begin
                if (accept) begin
                    b0_d    = rx_data[0];
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_B1;
                    if (|rx_data[7 -: PAD_BITS]) begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_B1: begin
                if (accept) begin
                    b1_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (accept) begin
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_WRITE;
                    if (!bad_q) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = idx_q[ADDR_W-1:0];
                        mem_wdata_d = {b0_q, b1_q, rx_data};
                    end
                end
            end
            ST_WRITE: begin
                idx_d = idx_inc;
                if (!bad_q) begin
                    words_loaded_d = idx_inc;
                end
                // idx is at most 2^ADDR_W, so widening it to 16 bits is lossless.
                if (16'(idx_inc) == n_q) begin
                    state_d = ST_CSUM;
                end else begin
                    state_d = ST_B0;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    loading_d = 1'b0;
                    if (rx_data == csum_q && !bad_q) begin
                        core_reset_d = 1'b0;
                        core_run_d   = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        load_err_d = 1'b1;
                        state_d    = ST_ERROR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            n_q            <= '0;
            n_hi_q         <= '0;
            idx_q          <= '0;
            csum_q         <= '0;
            bad_q          <= 1'b0;
            b0_q           <= 1'b0;
            b1_q           <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            core_reset_q   <= 1'b1;
            core_run_q     <= 1'b0;
            loading_q      <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            n_hi_q         <= n_hi_d;
            idx_q          <= idx_d;
            csum_q         <= csum_d;
            bad_q          <= bad_d;
            b0_q           <= b0_d;
            b1_q           <= b1_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            core_reset_q   <= core_reset_d;
            core_run_q     <= core_run_d;
            loading_q      <= loading_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_reset   = core_reset_q;
    assign core_run     = core_run_q;
    assign loading      = loading_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule
